peatc_test_sequencer: RTL and testbench



---
 rtl/peatc_test_sequencer_if.sv | 33 +++
 rtl/peatc_test_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_peatc_test_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peatc_test_sequencer_if.sv
// Bundle of the host-command, stimulus, ADC and FIFO signals seen by the
// PEATC test sequencer. The sequencer takes the master view; the Xillybus
// wrapper / acquisition environment takes the slave view.
interface peatc_test_sequencer_if;
    logic        cmd_open;
    logic        cmd_wren;
    logic [31:0] cmd_data;
    logic        cmd_full;
    logic        stim_trig;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        raw_wr_en;
    logic [15:0] raw_wr_data;
    logic        raw_full;
    logic        res_wr_en;
    logic [31:0] res_wr_data;
    logic        res_full;
    logic        busy;
    logic        done;
    logic        err_overrun;

    modport master (
        input  cmd_open, cmd_wren, cmd_data, adc_valid, adc_data, raw_full, res_full,
        output cmd_full, stim_trig, raw_wr_en, raw_wr_data, res_wr_en, res_wr_data,
               busy, done, err_overrun
    );

    modport slave (
        output cmd_open, cmd_wren, cmd_data, adc_valid, adc_data, raw_full, res_full,
        input  cmd_full, stim_trig, raw_wr_en, raw_wr_data, res_wr_en, res_wr_data,
               busy, done, err_overrun
    );
endinterface

// File: rtl/peatc_test_sequencer.sv
// PEATC acquisition run sequencer: decodes host START/ABORT commands, fires one
// stimulus trigger per epoch, forwards each epoch's ADC samples to the raw FIFO
// and finishes every run with a single status/result word in the result FIFO.
module peatc_test_sequencer #(
    parameter int ISI_SHIFT = 10,
    parameter int OVR_W     = 16
) (
    input  logic                   bus_clk,
    input  logic                   bus_rst,
    peatc_test_sequencer_if.master bus
);
    localparam int ISI_W = 8 + ISI_SHIFT;

    localparam logic [3:0] OP_START    = 4'd1;
    localparam logic [3:0] OP_ABORT    = 4'd2;
    localparam logic [3:0] ST_OK       = 4'd0;
    localparam logic [3:0] ST_ABORTED  = 4'd1;
    localparam logic [3:0] ST_BAD_PARM = 4'd2;
    localparam logic [3:0] ST_OVERRUN  = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRIG   = 3'd1,
        S_ACQ    = 3'd2,
        S_ISI    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         num_stim_q, num_stim_d;
    logic [11:0]        samples_q, samples_d;
    logic [7:0]         isi_q, isi_d;
    logic [7:0]         epoch_q, epoch_d;
    logic [11:0]        samp_cnt_q, samp_cnt_d;
    logic [ISI_W-1:0]   isi_cnt_q, isi_cnt_d;
    logic [OVR_W-1:0]   ovr_q, ovr_d;
    logic               err_q, err_d;
    logic               raw_wr_en_q, raw_wr_en_d;
    logic [15:0]        raw_wr_data_q, raw_wr_data_d;
    logic [31:0]        res_data_q, res_data_d;
    logic               stim_trig_q;
    logic               busy_q;
    logic               cmd_full_q;
    logic               start_s;
    logic               abort_s;

    // Result word: status, whole epochs, reserved nibble, zero-extended overrun count.
    function automatic logic [31:0] pack_result(input logic [3:0]       status,
                                                input logic [7:0]       epochs,
                                                input logic [OVR_W-1:0] overruns);
        return {status, epochs, 4'd0, 16'(overruns)};
    endfunction

    // Next-state, counter and output-data logic of the run sequencer.
    always_comb begin
        state_d       = state_q;
        num_stim_d    = num_stim_q;
        samples_d     = samples_q;
        isi_d         = isi_q;
        epoch_d       = epoch_q;
        samp_cnt_d    = samp_cnt_q;
        isi_cnt_d     = isi_cnt_q;
        ovr_d         = ovr_q;
        err_d         = err_q;
        raw_wr_en_d   = 1'b0;
        raw_wr_data_d = raw_wr_data_q;
        res_data_d    = res_data_q;

        start_s = bus.cmd_wren && (bus.cmd_data[31:28] == OP_START);
        // A closed host stream is treated exactly like an explicit ABORT.
        abort_s = (bus.cmd_wren && (bus.cmd_data[31:28] == OP_ABORT)) || !bus.cmd_open;

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    num_stim_d = bus.cmd_data[27:20];
                    samples_d  = bus.cmd_data[19:8];
                    isi_d      = bus.cmd_data[7:0];
                    err_d      = 1'b0;
                    ovr_d      = '0;
                    epoch_d    = 8'd0;
                    if ((bus.cmd_data[27:20] == 8'd0) || (bus.cmd_data[19:8] == 12'd0)) begin
                        state_d    = S_REPORT;
                        res_data_d = pack_result(ST_BAD_PARM, 8'd0, '0);
                    end else begin
                        state_d = S_TRIG;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRIG: begin
                samp_cnt_d = 12'd0;
                if (abort_s) begin
                    state_d    = S_REPORT;
                    res_data_d = pack_result(ST_ABORTED, epoch_q, ovr_q);
                end else begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                // Abort has priority: the coincident sample is neither written nor counted.
                if (abort_s) begin
                    state_d    = S_REPORT;
                    res_data_d = pack_result(ST_ABORTED, epoch_q, ovr_q);
                end else if (bus.adc_valid) begin
                    samp_cnt_d = samp_cnt_q + 12'd1;
                    if (bus.raw_full) begin
                        err_d = 1'b1;
                        ovr_d = (ovr_q == {OVR_W{1'b1}}) ? ovr_q : ovr_q + OVR_W'(1);
                    end else begin
                        raw_wr_en_d   = 1'b1;
                        raw_wr_data_d = bus.adc_data;
                    end
                    if (samp_cnt_d == samples_q) begin
                        epoch_d = epoch_q + 8'd1;
                        if (epoch_d == num_stim_q) begin
                            state_d    = S_REPORT;
                            res_data_d = pack_result(err_d ? ST_OVERRUN : ST_OK, epoch_d, ovr_d);
                        end else begin
                            state_d   = S_ISI;
                            isi_cnt_d = ISI_W'(isi_q) << ISI_SHIFT;
                        end
                    end else begin
                        state_d = S_ACQ;
                    end
                end else begin
                    state_d = S_ACQ;
                end
            end
            S_ISI: begin
                // A loaded value of 0 or 1 both give a single ISI cycle.
                if (abort_s) begin
                    state_d    = S_REPORT;
                    res_data_d = pack_result(ST_ABORTED, epoch_q, ovr_q);
                end else if (isi_cnt_q <= ISI_W'(1)) begin
                    state_d = S_TRIG;
                end else begin
                    isi_cnt_d = isi_cnt_q - ISI_W'(1);
                end
            end
            S_REPORT: begin
                state_d = bus.res_full ? S_REPORT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; async reset drops any run in progress.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q       <= S_IDLE;
            num_stim_q    <= 8'd0;
            samples_q     <= 12'd0;
            isi_q         <= 8'd0;
            epoch_q       <= 8'd0;
            samp_cnt_q    <= 12'd0;
            isi_cnt_q     <= '0;
            ovr_q         <= '0;
            err_q         <= 1'b0;
            raw_wr_en_q   <= 1'b0;
            raw_wr_data_q <= 16'd0;
            res_data_q    <= 32'd0;
            stim_trig_q   <= 1'b0;
            busy_q        <= 1'b0;
            cmd_full_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_stim_q    <= num_stim_d;
            samples_q     <= samples_d;
            isi_q         <= isi_d;
            epoch_q       <= epoch_d;
            samp_cnt_q    <= samp_cnt_d;
            isi_cnt_q     <= isi_cnt_d;
            ovr_q         <= ovr_d;
            err_q         <= err_d;
            raw_wr_en_q   <= raw_wr_en_d;
            raw_wr_data_q <= raw_wr_data_d;
            res_data_q    <= res_data_d;
            stim_trig_q   <= (state_d == S_TRIG);
            busy_q        <= (state_d != S_IDLE);
            cmd_full_q    <= (state_d == S_REPORT);
        end
    end

    assign bus.stim_trig   = stim_trig_q;
    assign bus.busy        = busy_q;
    assign bus.cmd_full    = cmd_full_q;
    assign bus.err_overrun = err_q;
    assign bus.raw_wr_en   = raw_wr_en_q;
    assign bus.raw_wr_data = raw_wr_data_q;
    assign bus.res_wr_data = res_data_q;
    // The result write must be qualified by this cycle's FIFO full flag, so it
    // is a gate of the REPORT state register and res_full rather than a flop.
    assign bus.res_wr_en   = (state_q == S_REPORT) && !bus.res_full;
    assign bus.done        = (state_q == S_REPORT) && !bus.res_full;
endmodule

// File: tb/tb_peatc_test_sequencer.sv
// Self-checking bench for peatc_test_sequencer: directed plan steps plus
// randomized runs checked against a per-run model of samples, drops and result.
module tb_peatc_test_sequencer;
    localparam int TB_ISI_SHIFT = 2;

    logic bus_clk = 1'b0;
    logic bus_rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] got_raw[$];
    int          got_raw_cyc[$];
    logic [31:0] got_res[$];
    int          got_res_cyc[$];
    int          stim_cnt = 0;
    int          done_cnt = 0;
    int          trig_cyc;

    peatc_test_sequencer_if bus_if ();

    peatc_test_sequencer #(.ISI_SHIFT(TB_ISI_SHIFT), .OVR_W(16)) dut (
        .bus_clk (bus_clk),
        .bus_rst (bus_rst),
        .bus     (bus_if)
    );

    always #5 bus_clk = ~bus_clk;

    always @(posedge bus_clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge bus_clk) begin
        if (bus_if.raw_wr_en === 1'b1) begin
            got_raw.push_back(bus_if.raw_wr_data);
            got_raw_cyc.push_back(cyc);
        end
        if (bus_if.res_wr_en === 1'b1) begin
            got_res.push_back(bus_if.res_wr_data);
            got_res_cyc.push_back(cyc);
        end
        if (bus_if.stim_trig === 1'b1) stim_cnt++;
        if (bus_if.done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] c);
        bus_if.cmd_wren = 1'b1;
        bus_if.cmd_data = c;
        step();
        bus_if.cmd_wren = 1'b0;
        bus_if.cmd_data = 32'($urandom);
    endtask

    // Wait (bounded) for stim_trig, driving ignored junk strobes meanwhile.
    task automatic wait_trig(input string tag);
        int k = 0;
        while (bus_if.stim_trig !== 1'b1 && k < 64) begin
            bus_if.adc_valid = 1'($urandom_range(0, 1));
            bus_if.adc_data  = 16'($urandom);
            step();
            k++;
        end
        chk({tag, ".trig_seen"}, 32'(k < 64), 32'd1);
        trig_cyc = cyc;
        bus_if.adc_valid = 1'($urandom_range(0, 1));
        bus_if.adc_data  = 16'($urandom);
        step();
        bus_if.adc_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int base);
        int k = 0;
        while (got_res.size() == base && k < 40) begin
            step();
            k++;
        end
        chk({tag, ".res_seen"}, 32'(k < 40), 32'd1);
    endtask

    task automatic feed(input logic [15:0] d, input logic full);
        bus_if.adc_valid = 1'b1;
        bus_if.adc_data  = d;
        bus_if.raw_full  = full;
        step();
        bus_if.adc_valid = 1'b0;
        bus_if.raw_full  = 1'b0;
    endtask

    // One complete run; the model is the list of kept samples and the drop count.
    task automatic run_epochs(input string name, input logic [31:0] cmd, input int gap_pct,
                              input int full_pct, input logic [63:0] full_mask,
                              input bit seq_data, input int hold_full);
        logic [7:0]  ns;
        logic [11:0] sp;
        int          isi_len, idx, ovr, raw_base, res_base, stim0, done0, n_got;
        logic [15:0] exp_raw[$];
        int          exp_cyc[$];
        int          last_cyc[$];
        int          trigs[$];
        logic        full;
        logic [15:0] d;
        logic [31:0] exp_word;
        ns = cmd[27:20];
        sp = cmd[19:8];
        isi_len = (int'(cmd[7:0]) << TB_ISI_SHIFT);
        if (isi_len == 0) isi_len = 1;
        idx = 0; ovr = 0;
        raw_base = got_raw.size(); res_base = got_res.size();
        stim0 = stim_cnt; done0 = done_cnt;
        bus_if.res_full = (hold_full > 0);
        send_cmd(cmd);
        for (int e = 0; e < int'(ns); e++) begin
            wait_trig(name);
            trigs.push_back(trig_cyc);
            for (int s = 0; s < int'(sp); ) begin
                if (int'($urandom_range(0, 99)) < gap_pct) begin
                    bus_if.adc_valid = 1'b0;
                    bus_if.raw_full  = 1'($urandom_range(0, 1));
                end else begin
                    d = seq_data ? 16'(idx + 1) : 16'($urandom);
                    full = full_mask[idx % 64] | (int'($urandom_range(0, 99)) < full_pct);
                    bus_if.adc_valid = 1'b1;
                    bus_if.adc_data  = d;
                    bus_if.raw_full  = full;
                    if (full) ovr++;
                    else begin
                        exp_raw.push_back(d);
                        exp_cyc.push_back(cyc + 1);
                    end
                    if (s == int'(sp) - 1) last_cyc.push_back(cyc);
                    s++;
                    idx++;
                end
                step();
            end
            bus_if.adc_valid = 1'b0;
            bus_if.raw_full  = 1'b0;
        end
        for (int i = 0; i < hold_full; i++) begin
            chk({name, ".cmd_full_hold"}, 32'(bus_if.cmd_full), 32'd1);
            chk({name, ".no_res_while_full"}, 32'(bus_if.res_wr_en), 32'd0);
            step();
        end
        bus_if.res_full = 1'b0;
        wait_res(name, res_base);
        repeat (4) step();
        exp_word = {(ovr > 0) ? 4'd3 : 4'd0, ns, 4'd0, 16'(ovr)};
        chk({name, ".stim_count"}, 32'(stim_cnt - stim0), 32'(ns));
        n_got = got_raw.size() - raw_base;
        chk({name, ".raw_count"}, 32'(n_got), 32'(exp_raw.size()));
        for (int i = 0; i < exp_raw.size() && i < n_got; i++) begin
            chk({name, ".raw_data"}, 32'(got_raw[raw_base + i]), 32'(exp_raw[i]));
            chk({name, ".raw_latency"}, 32'(got_raw_cyc[raw_base + i]), 32'(exp_cyc[i]));
        end
        chk({name, ".res_count"}, 32'(got_res.size() - res_base), 32'd1);
        if (got_res.size() > res_base) chk({name, ".result"}, got_res[res_base], exp_word);
        chk({name, ".done_count"}, 32'(done_cnt - done0), 32'd1);
        chk({name, ".err_overrun"}, 32'(bus_if.err_overrun), 32'(ovr > 0));
        chk({name, ".busy_after"}, 32'(bus_if.busy), 32'd0);
        for (int e = 1; e < trigs.size() && e <= last_cyc.size(); e++)
            chk({name, ".isi_gap"}, 32'(trigs[e] - last_cyc[e - 1]), 32'(isi_len + 1));
    endtask

    // ABORT (or closing the stream) partway into epoch 2 of a 3-epoch run.
    task automatic run_abort(input string name, input bit via_open);
        int          raw_base, res_base, stim0, n_got;
        logic [15:0] exp_raw[$];
        raw_base = got_raw.size(); res_base = got_res.size(); stim0 = stim_cnt;
        send_cmd(32'h1030_0400);
        wait_trig(name);
        for (int i = 1; i <= 4; i++) begin
            feed(16'(i), 1'b0);
            exp_raw.push_back(16'(i));
        end
        wait_trig(name);
        feed(16'd11, 1'b0); exp_raw.push_back(16'd11);
        feed(16'd12, 1'b0); exp_raw.push_back(16'd12);
        if (!via_open) begin
            bus_if.cmd_wren = 1'b1;
            bus_if.cmd_data = 32'h2000_0000;
            feed(16'd13, 1'b0);
            bus_if.cmd_wren = 1'b0;
        end else begin
            feed(16'd13, 1'b0); exp_raw.push_back(16'd13);
            bus_if.cmd_open = 1'b0;
            feed(16'd14, 1'b0);
            bus_if.cmd_open = 1'b1;
        end
        wait_res(name, res_base);
        repeat (20) step();
        chk({name, ".stim_count"}, 32'(stim_cnt - stim0), 32'd2);
        n_got = got_raw.size() - raw_base;
        chk({name, ".raw_count"}, 32'(n_got), 32'(exp_raw.size()));
        for (int i = 0; i < exp_raw.size() && i < n_got; i++)
            chk({name, ".raw_data"}, 32'(got_raw[raw_base + i]), 32'(exp_raw[i]));
        chk({name, ".res_count"}, 32'(got_res.size() - res_base), 32'd1);
        if (got_res.size() > res_base) chk({name, ".result"}, got_res[res_base], 32'h1010_0000);
        chk({name, ".busy_after"}, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic run_bad(input string name, input logic [31:0] cmd);
        int res_base, stim0, start_cyc;
        res_base = got_res.size(); stim0 = stim_cnt; start_cyc = cyc;
        send_cmd(cmd);
        wait_res(name, res_base);
        step();
        chk({name, ".stim_count"}, 32'(stim_cnt - stim0), 32'd0);
        if (got_res.size() > res_base) begin
            chk({name, ".result"}, got_res[res_base], 32'h2000_0000);
            chk({name, ".within_3"}, 32'((got_res_cyc[res_base] - start_cyc) <= 3), 32'd1);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".flags"}, 32'({bus_if.stim_trig, bus_if.raw_wr_en, bus_if.res_wr_en,
                                   bus_if.busy, bus_if.done, bus_if.err_overrun,
                                   bus_if.cmd_full}), 32'd0);
        chk({name, ".raw_wr_data"}, 32'(bus_if.raw_wr_data), 32'd0);
        chk({name, ".res_wr_data"}, bus_if.res_wr_data, 32'd0);
    endtask

    initial begin
        logic [7:0]  r_ns, r_isi;
        logic [11:0] r_sp;
        int          res_base;
        bus_if.cmd_open  = 1'b1;
        bus_if.cmd_wren  = 1'b0;
        bus_if.cmd_data  = 32'd0;
        bus_if.adc_valid = 1'b0;
        bus_if.adc_data  = 16'd0;
        bus_if.raw_full  = 1'b0;
        bus_if.res_full  = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        bus_rst = 1'b0;
        step();

        run_epochs("t1_basic", 32'h1020_0400, 0, 0, 64'd0, 1'b1, 0);
        run_epochs("t2_isi", 32'h1020_0201, 0, 0, 64'd0, 1'b1, 0);
        run_epochs("t3_overrun", 32'h1010_0800, 0, 0, 64'h52, 1'b1, 0);
        run_abort("t4_abort_cmd", 1'b0);
        run_abort("t4_abort_open", 1'b1);
        run_bad("t5_zero_samples", 32'h1010_0000);
        run_bad("t5_zero_stims", 32'h1000_0400);
        run_epochs("t6_res_full", 32'h1010_0300, 0, 0, 64'd0, 1'b1, 5);

        // ABORT while idle does nothing.
        res_base = got_res.size();
        send_cmd(32'h2000_0000);
        repeat (5) step();
        chk("idle_abort.busy", 32'(bus_if.busy), 32'd0);
        chk("idle_abort.res_count", 32'(got_res.size() - res_base), 32'd0);

        for (int r = 0; r < 8; r++) begin
            r_ns  = 8'($urandom_range(1, 3));
            r_sp  = 12'($urandom_range(1, 5));
            r_isi = 8'($urandom_range(0, 2));
            run_epochs("rand", {4'h1, r_ns, r_sp, r_isi}, 30, 20, 64'd0, 1'b0, 0);
        end

        // Reset in the middle of acquisition.
        res_base = got_res.size();
        send_cmd(32'h1010_0800);
        wait_trig("t7_reset");
        feed(16'h1234, 1'b1);
        feed(16'hA5A5, 1'b0);
        chk("t7_reset.pre_err", 32'(bus_if.err_overrun), 32'd1);
        bus_rst = 1'b1;
        #1;
        chk_all_zero("t7_reset");
        repeat (3) step();
        bus_rst = 1'b0;
        repeat (10) step();
        chk("t7_reset.busy", 32'(bus_if.busy), 32'd0);
        chk("t7_reset.res_count", 32'(got_res.size() - res_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
